// File: rtl/magnitude_search.sv
// magnitude_search: binary-search initiator that converges on a comparator's hidden operand.
// Define MAGNITUDE_SEARCH_ERR_CHECK_EN to abort a search on any verdict that is not one-hot.
module magnitude_search #(
  parameter int WIDTH = 4,
  localparam int STEPS_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   probe,
  output logic               probe_valid,
  input  logic               rsp_valid,
  input  logic               cmp_gt,
  input  logic               cmp_eq,
  input  logic               cmp_lt,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [WIDTH-1:0]   result,
  output logic [STEPS_W-1:0] steps,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_VAL     = '1;
  localparam logic [WIDTH-1:0] FIRST_PROBE = MAX_VAL >> 1;

  state_t             state_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [STEPS_W-1:0] count_reg;

  logic               accept;
  logic               malformed;
  logic               verdict_eq;
  logic               verdict_gt;
  logic               last_probe;
  logic               finish;
  logic [STEPS_W-1:0] count_next;
  logic [WIDTH-1:0]   lo_next;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH:0]     mid_sum;
  logic [WIDTH-1:0]   probe_next;

  // probe_valid is only ever high in PROBE, so it alone qualifies acceptance.
  assign accept     = probe_valid & rsp_valid;
  assign count_next = count_reg + 1'b1;

`ifdef MAGNITUDE_SEARCH_ERR_CHECK_EN
  assign malformed = ({cmp_gt, cmp_eq, cmp_lt} != 3'b100) &&
                     ({cmp_gt, cmp_eq, cmp_lt} != 3'b010) &&
                     ({cmp_gt, cmp_eq, cmp_lt} != 3'b001);
`else
  logic unused_lt;
  assign malformed = 1'b0;
  assign unused_lt = cmp_lt;
`endif

  // eq beats gt; anything that is neither eq nor gt (including all-zero) walks down as lt.
  assign verdict_eq = cmp_eq;
  assign verdict_gt = cmp_gt & ~cmp_eq;

  always_comb begin
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    last_probe = 1'b0;
    if (verdict_gt) begin
      if (probe == hi_reg) begin
        last_probe = 1'b1;
      end else begin
        lo_next = probe + 1'b1;
      end
    end else begin
      if (probe == lo_reg) begin
        last_probe = 1'b1;
      end else begin
        hi_next = probe - 1'b1;
      end
    end
  end

  // One extra bit keeps lo+hi from overflowing before the halving shift.
  assign mid_sum    = {1'b0, lo_next} + {1'b0, hi_next};
  assign probe_next = mid_sum[WIDTH:1];
  assign finish     = malformed | verdict_eq | last_probe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      lo_reg      <= '0;
      hi_reg      <= '0;
      count_reg   <= '0;
      probe       <= '0;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      result      <= '0;
      steps       <= '0;
`ifdef MAGNITUDE_SEARCH_ERR_CHECK_EN
      err         <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lo_reg      <= '0;
            hi_reg      <= MAX_VAL;
            count_reg   <= '0;
            probe       <= FIRST_PROBE;
            probe_valid <= 1'b1;
            busy        <= 1'b1;
            found       <= 1'b0;
            result      <= '0;
            steps       <= '0;
`ifdef MAGNITUDE_SEARCH_ERR_CHECK_EN
            err         <= 1'b0;
`endif
            state_reg   <= PROBE;
          end
        end

        PROBE: begin
          if (accept) begin
            count_reg <= count_next;
            if (finish) begin
              probe_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              steps       <= count_next;
              found       <= verdict_eq & ~malformed;
              result      <= (verdict_eq & ~malformed) ? probe : '0;
`ifdef MAGNITUDE_SEARCH_ERR_CHECK_EN
              err         <= malformed;
`endif
              state_reg   <= DONE;
            end else begin
              lo_reg <= lo_next;
              hi_reg <= hi_next;
              probe  <= probe_next;
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifndef MAGNITUDE_SEARCH_ERR_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_magnitude_search.sv
// Scoreboard bench for magnitude_search: expected probes and completions are queued at start
// and retired as the DUT presents probes and pulses done.
module tb_magnitude_search;
  localparam int WIDTH = 4;
  localparam int SW    = $clog2(WIDTH + 2);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] probe;
  logic             probe_valid;
  logic             rsp_valid;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    steps;
  logic             err;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int found;
    int result;
    int steps;
    int err;
    int lat;
  } exp_t;

  exp_t res_q[$];
  int   probe_q[$];

  magnitude_search #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .probe      (probe),
    .probe_valid(probe_valid),
    .rsp_valid  (rsp_valid),
    .cmp_gt     (cmp_gt),
    .cmp_eq     (cmp_eq),
    .cmp_lt     (cmp_lt),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .result     (result),
    .steps      (steps),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // mode 0: ideal comparator, 1: always gt, 2: always lt, 3: first verdict gt+eq then ideal
  task automatic set_verdict(input int mode, input int hidden, input bit first);
    int p;
    p = int'(probe);
    cmp_gt = (hidden > p);
    cmp_eq = (hidden == p);
    cmp_lt = (hidden < p);
    if (mode == 1) {cmp_gt, cmp_eq, cmp_lt} = 3'b100;
    if (mode == 2) {cmp_gt, cmp_eq, cmp_lt} = 3'b001;
    if (mode == 3 && first) {cmp_gt, cmp_eq, cmp_lt} = 3'b110;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/probe"}, int'(probe), 0);
    check({name, "/probe_valid"}, int'(probe_valid), 0);
    check({name, "/busy"}, int'(busy), 0);
    check({name, "/done"}, int'(done), 0);
    check({name, "/found"}, int'(found), 0);
    check({name, "/result"}, int'(result), 0);
    check({name, "/steps"}, int'(steps), 0);
    check({name, "/err"}, int'(err), 0);
  endtask

  // seq holds the expected probes one nibble each, first probe in the most significant used nibble.
  task automatic run_search(input string name, input int hidden, input int mode, input int delay,
                            input logic [63:0] seq, input int n, input int exp_found,
                            input int exp_result, input int exp_err, input bit poke);
    exp_t e;
    int   s_cyc;
    int   waited;
    int   nprobe;
    bit   finished;
    for (int i = 0; i < n; i++) probe_q.push_back(int'(seq[4*(n-1-i) +: 4]));
    e.found  = exp_found;
    e.result = exp_result;
    e.steps  = n;
    e.err    = exp_err;
    e.lat    = n * (delay + 1);
    res_q.push_back(e);

    start = 1'b1;
    s_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    check({name, "/first_valid"}, int'(probe_valid), 1);
    check({name, "/first_busy"}, int'(busy), 1);

    waited   = 0;
    nprobe   = 0;
    finished = 1'b0;
    for (int t = 0; t < 200 && !finished; t++) begin
      rsp_valid = 1'b0;
      start     = 1'b0;
      if (done) begin
        finished = 1'b1;
        if (res_q.size() == 0) begin
          check({name, "/unexpected_done"}, 1, 0);
        end else begin
          e = res_q.pop_front();
          check({name, "/found"}, int'(found), e.found);
          check({name, "/result"}, int'(result), e.result);
          check({name, "/steps"}, int'(steps), e.steps);
          check({name, "/err"}, int'(err), e.err);
          check({name, "/latency"}, cyc - s_cyc, e.lat);
          check({name, "/valid_at_done"}, int'(probe_valid), 0);
          check({name, "/probes_left"}, probe_q.size(), 0);
        end
        $display("search %s: hidden=%0d probes=%0d found=%0d result=%0d steps=%0d err=%0d",
                 name, hidden, nprobe, found, result, steps, err);
        if (poke) start = 1'b1;
      end else if (probe_valid) begin
        if (probe_q.size() == 0) check({name, "/extra_probe"}, int'(probe), -1);
        else check({name, "/probe"}, int'(probe), probe_q[0]);
        if (waited >= delay) begin
          set_verdict(mode, hidden, nprobe == 0);
          rsp_valid = 1'b1;
          if (probe_q.size() != 0) void'(probe_q.pop_front());
          nprobe++;
          waited = 0;
        end else begin
          waited++;
        end
        if (poke && (cyc - s_cyc == 5)) start = 1'b1;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    rsp_valid = 1'b0;
    if (!finished) begin
      check({name, "/timeout"}, 0, 1);
      probe_q.delete();
      res_q.delete();
    end else begin
      check({name, "/done_pulse"}, int'(done), 0);
      check({name, "/idle_valid"}, int'(probe_valid), 0);
      check({name, "/found_hold"}, int'(found), e.found);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    rsp_valid = 1'b0;
    cmp_gt    = 1'b0;
    cmp_eq    = 1'b0;
    cmp_lt    = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_search("hidden7", 7, 0, 0, 64'h7, 1, 1, 7, 0, 1'b0);
    run_search("hidden0", 0, 0, 0, 64'h7310, 4, 1, 0, 0, 1'b0);
    run_search("hidden15", 15, 0, 0, 64'h7BDEF, 5, 1, 15, 0, 1'b0);
    run_search("always_gt", 0, 1, 0, 64'h7BDEF, 5, 0, 0, 0, 1'b0);
    run_search("always_lt", 0, 2, 0, 64'h7310, 4, 0, 0, 0, 1'b0);
    run_search("hidden9_slow", 9, 0, 3, 64'h7B9, 3, 1, 9, 0, 1'b1);

    // Reset lands on the second probe, coincident with a verdict and a start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("midrst/probe1", int'(probe), 7);
    set_verdict(0, 9, 1'b1);
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("midrst/probe2", int'(probe), 11);
    rst       = 1'b1;
    start     = 1'b1;
    set_verdict(0, 9, 1'b0);
    rsp_valid = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    rsp_valid = 1'b0;
    check_all_zero("midrst");
    @(negedge clk);
    check("midrst/still_idle", int'(probe_valid), 0);
    $display("search midrst: reset during probe 2, outputs cleared");

    run_search("hidden5", 5, 0, 0, 64'h735, 3, 1, 5, 0, 1'b0);
`ifdef MAGNITUDE_SEARCH_ERR_CHECK_EN
    run_search("gt_and_eq", 7, 3, 0, 64'h7, 1, 0, 0, 1, 1'b0);
`else
    run_search("gt_and_eq", 7, 3, 0, 64'h7, 1, 1, 7, 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
